// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream,
// writes it into memory as 16-bit words and then releases the processor reset.
// Image: LEN_H, LEN_L, then N words (high byte first), then one checksum byte.
module boot_loader #(
    parameter logic [15:0] BASE_ADR  = 16'h0000,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic [15:0] mem_adr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StWrite,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e      state_q, state_d;

    // Image bookkeeping
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;

    // Registered outputs
    logic [15:0] mem_adr_q, mem_adr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q;
    logic        cpu_reset_q;
    logic        done_q;
    logic        error_q;
    logic [15:0] words_q, words_d;

    logic        accept;
    logic [15:0] len_in;
    logic        last_word;

    // Full 16-bit length as it stands while LEN_L is on the bus
    assign len_in    = {len_hi_q, in_byte};
    assign accept    = in_valid & in_ready;
    assign last_word = ((idx_q + 16'd1) == len_q);

    // in_ready is a pure decode of the current state
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StLenHi, StLenLo, StDataHi, StDataLo, StCheck: in_ready = 1'b1;
            default:                                       in_ready = 1'b0;
        endcase
    end

    // Next-state and datapath next values; everything holds unless a byte is accepted
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        hi_d        = hi_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        words_d     = words_q;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StLenHi: begin
                if (accept) begin
                    len_hi_d = in_byte;
                    csum_d   = csum_q ^ in_byte;
                    state_d  = StLenLo;
                end
            end

            StLenLo: begin
                if (accept) begin
                    len_d  = len_in;
                    csum_d = csum_q ^ in_byte;
                    if (32'(len_in) > MEM_WORDS) begin
                        state_d = StError;
                    end else if (len_in == 16'd0) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StDataHi;
                    end
                end
            end

            StDataHi: begin
                if (accept) begin
                    hi_d    = in_byte;
                    csum_d  = csum_q ^ in_byte;
                    state_d = StDataLo;
                end
            end

            StDataLo: begin
                if (accept) begin
                    // Address and data are loaded here so they are valid in the WRITE cycle
                    mem_wdata_d = {hi_q, in_byte};
                    mem_adr_d   = BASE_ADR + idx_q;
                    csum_d      = csum_q ^ in_byte;
                    state_d     = StWrite;
                end
            end

            StWrite: begin
                // Single-cycle state; no byte is consumed here
                idx_d   = idx_q + 16'd1;
                words_d = words_q + 16'd1;
                state_d = last_word ? StCheck : StDataHi;
            end

            StCheck: begin
                if (accept) begin
                    state_d = (in_byte == csum_q) ? StDone : StError;
                end
            end

            StDone, StError: begin
                state_d = state_q;
            end

            default: begin
                state_d = StError;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StLenHi;
        end else begin
            state_q <= state_d;
        end
    end

    // Length, word index, pending high byte and running checksum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi_q <= 8'h00;
            len_q    <= 16'h0000;
            hi_q     <= 8'h00;
            idx_q    <= 16'h0000;
            csum_q   <= 8'h00;
        end else begin
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            hi_q     <= hi_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
        end
    end

    // Memory write port: strobe tracks the WRITE state, address/data hold between writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_q    <= 1'b0;
            mem_adr_q   <= 16'h0000;
            mem_wdata_q <= 16'h0000;
        end else begin
            mem_we_q    <= (state_d == StWrite);
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Status outputs registered from the next state so they line up with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= 16'h0000;
        end else begin
            cpu_reset_q <= (state_d != StDone);
            done_q      <= (state_d == StDone);
            error_q     <= (state_d == StError);
            words_q     <= words_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_adr      = mem_adr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed, table-driven bench for boot_loader.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic [15:0] mem_adr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    boot_loader #(
        .BASE_ADR (16'h0000),
        .MEM_WORDS(256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .in_ready    (in_ready),
        .mem_adr     (mem_adr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .cpu_reset   (cpu_reset),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    typedef struct packed {
        logic        rdy;
        logic        we;
        logic [15:0] adr;
        logic [15:0] wd;
        logic        dn;
        logic        er;
        logic        cr;
        logic [15:0] wl;
    } exp_t;

    typedef struct {
        logic       v;
        logic [7:0] b;
        exp_t       e;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   we_count = 0;
    int   we_base;
    vec_t a_tab[10];
    vec_t q[$];
    exp_t rst_e;
    exp_t prev;

    // Counts write strobes seen at rising edges
    always @(posedge clk) begin
        if (mem_we === 1'b1) we_count <= we_count + 1;
    end

    function automatic vec_t mk(input logic v, input logic [7:0] b, input logic rdy,
                                input logic we, input logic [15:0] adr, input logic [15:0] wd,
                                input logic dn, input logic er, input logic cr,
                                input logic [15:0] wl);
        vec_t r;
        r.v = v;
        r.b = b;
        r.e = '{rdy: rdy, we: we, adr: adr, wd: wd, dn: dn, er: er, cr: cr, wl: wl};
        return r;
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = {in_ready, mem_we, mem_adr, mem_wdata, done, error, cpu_reset, words_loaded};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got rdy=%b we=%b adr=%h wd=%h done=%b err=%b cpu_rst=%b wl=%0d ; want rdy=%b we=%b adr=%h wd=%h done=%b err=%b cpu_rst=%b wl=%0d",
                     name, a.rdy, a.we, a.adr, a.wd, a.dn, a.er, a.cr, a.wl,
                     e.rdy, e.we, e.adr, e.wd, e.dn, e.er, e.cr, e.wl);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Applies the queued vectors one clock each, checking outputs 1 time unit after the edge
    task automatic run_q(input string tag);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            in_valid = q[i].v;
            in_byte  = q[i].b;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i), q[i].e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        q.delete();
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge
    task automatic do_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check($sformatf("%s_reset", tag), rst_e);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        rst_e = '{rdy: 1'b1, we: 1'b0, adr: 16'h0, wd: 16'h0, dn: 1'b0, er: 1'b0, cr: 1'b1,
                  wl: 16'd0};

        //            v  byte   rdy we adr     wd       dn er cr wl
        a_tab[0] = mk(1, 8'h00, 1, 0, 16'h0, 16'h0000, 0, 0, 1, 16'd0);
        a_tab[1] = mk(1, 8'h02, 1, 0, 16'h0, 16'h0000, 0, 0, 1, 16'd0);
        a_tab[2] = mk(1, 8'h12, 1, 0, 16'h0, 16'h0000, 0, 0, 1, 16'd0);
        a_tab[3] = mk(1, 8'h34, 0, 1, 16'h0, 16'h1234, 0, 0, 1, 16'd0);
        a_tab[4] = mk(1, 8'hAB, 1, 0, 16'h0, 16'h1234, 0, 0, 1, 16'd1);
        a_tab[5] = mk(1, 8'hAB, 1, 0, 16'h0, 16'h1234, 0, 0, 1, 16'd1);
        a_tab[6] = mk(1, 8'hCD, 0, 1, 16'h1, 16'hABCD, 0, 0, 1, 16'd1);
        a_tab[7] = mk(1, 8'h42, 1, 0, 16'h1, 16'hABCD, 0, 0, 1, 16'd2);
        a_tab[8] = mk(1, 8'h42, 0, 0, 16'h1, 16'hABCD, 1, 0, 0, 16'd2);
        a_tab[9] = mk(1, 8'h55, 0, 0, 16'h1, 16'hABCD, 1, 0, 0, 16'd2);

        // Good two-word image
        do_reset("a");
        we_base = we_count;
        for (int i = 0; i < 10; i++) q.push_back(a_tab[i]);
        run_q("good");
        check_int("good_writes", we_count - we_base, 2);

        // Bad checksum
        do_reset("b");
        we_base = we_count;
        for (int i = 0; i < 8; i++) q.push_back(a_tab[i]);
        q.push_back(mk(1, 8'h43, 0, 0, 16'h1, 16'hABCD, 0, 1, 1, 16'd2));
        q.push_back(mk(1, 8'h42, 0, 0, 16'h1, 16'hABCD, 0, 1, 1, 16'd2));
        run_q("badsum");
        check_int("badsum_writes", we_count - we_base, 2);

        // Empty image
        do_reset("c");
        we_base = we_count;
        q.push_back(mk(1, 8'h00, 1, 0, 16'h0, 16'h0000, 0, 0, 1, 16'd0));
        q.push_back(mk(1, 8'h00, 1, 0, 16'h0, 16'h0000, 0, 0, 1, 16'd0));
        q.push_back(mk(1, 8'h00, 0, 0, 16'h0, 16'h0000, 1, 0, 0, 16'd0));
        run_q("empty");
        check_int("empty_writes", we_count - we_base, 0);

        // Oversized length 0x0101 > 256
        do_reset("d");
        we_base = we_count;
        q.push_back(mk(1, 8'h01, 1, 0, 16'h0, 16'h0000, 0, 0, 1, 16'd0));
        q.push_back(mk(1, 8'h01, 0, 0, 16'h0, 16'h0000, 0, 1, 1, 16'd0));
        q.push_back(mk(1, 8'h12, 0, 0, 16'h0, 16'h0000, 0, 1, 1, 16'd0));
        q.push_back(mk(1, 8'h34, 0, 0, 16'h0, 16'h0000, 0, 1, 1, 16'd0));
        run_q("toolong");
        check_int("toolong_writes", we_count - we_base, 0);

        // Good image with an idle cycle inserted wherever the loader is waiting for a byte
        do_reset("e");
        we_base = we_count;
        prev = rst_e;
        for (int i = 0; i < 10; i++) begin
            if (prev.rdy) begin
                q.push_back(mk(0, 8'hEE, prev.rdy, prev.we, prev.adr, prev.wd,
                               prev.dn, prev.er, prev.cr, prev.wl));
            end
            q.push_back(a_tab[i]);
            prev = a_tab[i].e;
        end
        run_q("stall");
        check_int("stall_writes", we_count - we_base, 2);

        // Reset after the first write, then the full image again
        do_reset("f");
        for (int i = 0; i < 5; i++) q.push_back(a_tab[i]);
        run_q("abort");
        do_reset("f2");
        we_base = we_count;
        for (int i = 0; i < 10; i++) q.push_back(a_tab[i]);
        run_q("reload");
        check_int("reload_writes", we_count - we_base, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
